// File: rtl/sync_mod_cascade.sv
// Programmable modulo-MODULUS up/down counter stage with a combinational
// terminal-count carry, so stages can be chained into synchronous multi-digit counters.
module sync_mod_cascade #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce_in,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flag,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             tc_q,
  output logic             wrapped
);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
    $error("sync_mod_cascade: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
  end

  // The modulus itself needs WIDTH+1 bits when MODULUS == 2**WIDTH.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   MAX_W = MOD_W - (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_Q = MAX_W[WIDTH-1:0];

  logic [WIDTH:0]   inc;
  logic [WIDTH:0]   dec;
  logic [WIDTH:0]   lv_ext;
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] q_next;

  // Compare in the widened domain before truncating, so the full-range case wraps cleanly.
  assign inc     = {1'b0, Q} + (WIDTH+1)'(1);
  assign dec     = {1'b0, Q} - (WIDTH+1)'(1);
  assign lv_ext  = {1'b0, load_val};
  assign at_max  = (inc == MOD_W);
  assign at_zero = dec[WIDTH];

  assign tc = reset & ce_in & ~load & (up ? at_max : at_zero);

  always_comb begin
    // NOTE: default assigned first so every path drives q_next; otherwise a latch is inferred.
    q_next = Q;
    if (load) begin
      q_next = (lv_ext < MOD_W) ? load_val : MAX_Q;
    end else if (ce_in) begin
      if (up) q_next = at_max  ? '0    : inc[WIDTH-1:0];
      else    q_next = at_zero ? MAX_Q : dec[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      Q       <= '0;
      tc_q    <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      Q    <= q_next;
      tc_q <= tc;
      if (tc)            wrapped <= 1'b1;
      else if (clr_flag) wrapped <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_mod_cascade.sv
// Self-checking bench for sync_mod_cascade: directed vector table, gapped enable,
// async reset, randomized run against an arithmetic model, and a two-digit chain.
module tb_sync_mod_cascade;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce_in, up, load, clr_flag;
  logic [3:0] load_val;
  logic [3:0] q, q16;
  logic       tc, tc_q, wrapped;
  logic       tc16, tc_q16, wrapped16;

  logic       ch_ce;
  logic [3:0] u_q, t_q;
  logic       u_tc, t_tc, u_tcq, t_tcq, u_wr, t_wr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_mod_cascade #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .reset(rst_n), .ce_in(ce_in), .up(up), .load(load),
    .load_val(load_val), .clr_flag(clr_flag), .Q(q), .tc(tc), .tc_q(tc_q), .wrapped(wrapped)
  );

  sync_mod_cascade #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .reset(rst_n), .ce_in(ce_in), .up(up), .load(load),
    .load_val(load_val), .clr_flag(clr_flag), .Q(q16), .tc(tc16), .tc_q(tc_q16), .wrapped(wrapped16)
  );

  sync_mod_cascade #(.WIDTH(4), .MODULUS(10)) units (
    .clk(clk), .reset(rst_n), .ce_in(ch_ce), .up(1'b1), .load(1'b0),
    .load_val(4'd0), .clr_flag(1'b0), .Q(u_q), .tc(u_tc), .tc_q(u_tcq), .wrapped(u_wr)
  );

  sync_mod_cascade #(.WIDTH(4), .MODULUS(10)) tens (
    .clk(clk), .reset(rst_n), .ce_in(u_tc), .up(1'b1), .load(1'b0),
    .load_val(4'd0), .clr_flag(1'b0), .Q(t_q), .tc(t_tc), .tc_q(t_tcq), .wrapped(t_wr)
  );

  typedef struct {
    bit         ld;
    bit         ce;
    bit         up;
    logic [3:0] lv;
    bit         clr;
    int         exp_q;
    bit         exp_tc;
    bit         exp_wr;
  } vec_t;

  typedef struct {
    int q;
    bit tcq;
    bit wr;
  } mstate_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(bit ld, bit ce, bit u, int lv, bit clr, int eq, bit et, bit ew);
    vec_t v;
    v.ld = ld; v.ce = ce; v.up = u; v.lv = 4'(lv); v.clr = clr;
    v.exp_q = eq; v.exp_tc = et; v.exp_wr = ew;
    return v;
  endfunction

  // Reference model: counter behaviour expressed with plain modular arithmetic.
  function automatic bit model_tc(mstate_t s, int m, bit ld, bit ce, bit u);
    return ce && !ld && (u ? (s.q == m - 1) : (s.q == 0));
  endfunction

  function automatic mstate_t model_step(mstate_t s, int m, bit ld, int lv, bit ce, bit u, bit clr);
    mstate_t n;
    bit      t;
    t = model_tc(s, m, ld, ce, u);
    n.q   = ld ? ((lv < m) ? lv : m - 1) : (ce ? (u ? (s.q + 1) % m : (s.q + m - 1) % m) : s.q);
    n.tcq = t;
    n.wr  = t ? 1'b1 : (clr ? 1'b0 : s.wr);
    return n;
  endfunction

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    mstate_t m10, m16;
    int      adv, tcs, first_tc, last_q, tc_gap;
    logic [1:0] up2;
    bit      saw_nine;

    // Directed table: count-up wrap, down count with wrap, clamp, clr vs set, load priority.
    for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 1, 1, 0, 0, (i + 1) % 10, i == 9, i == 9));
    vecs.push_back(mk(1, 0, 1, 2,  0, 2, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0,  0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0,  0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0,  0, 9, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0,  0, 8, 0, 1));
    vecs.push_back(mk(1, 0, 0, 13, 0, 9, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,  1, 9, 0, 0));
    vecs.push_back(mk(1, 1, 1, 4,  0, 4, 0, 0));
    vecs.push_back(mk(1, 0, 1, 9,  0, 9, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0,  1, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0,  0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 15, 0, 9, 0, 1));
    vecs.push_back(mk(1, 0, 1, 10, 0, 9, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0,  0, 0, 0, 1));

    rst_n = 1'b0; ce_in = 1'b1; up = 1'b0; load = 1'b0; load_val = '0; clr_flag = 1'b0;
    ch_ce = 1'b0;
    #12;
    check("reset_q", q, 0);
    check("reset_tcq", tc_q, 0);
    check("reset_wr", wrapped, 0);
    check("reset_tc_gated", tc, 0);
    ce_in = 1'b0;
    #10 rst_n = 1'b1;

    foreach (vecs[i]) begin
      load = vecs[i].ld; ce_in = vecs[i].ce; up = vecs[i].up;
      load_val = vecs[i].lv; clr_flag = vecs[i].clr;
      #1;
      check($sformatf("vec%0d_tc", i), tc, vecs[i].exp_tc);
      tick();
      check($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
      check($sformatf("vec%0d_tcq", i), tc_q, vecs[i].exp_tc);
      check($sformatf("vec%0d_wr", i), wrapped, vecs[i].exp_wr);
    end

    // Gapped enable from a 2-bit upstream counter's terminal decode.
    load = 1'b0; clr_flag = 1'b0; up = 1'b1;
    up2 = 2'd0; adv = 0; tcs = 0; first_tc = -1; tc_gap = -1; last_q = q;
    for (int c = 0; c < 80; c++) begin
      ce_in = (up2 == 2'd3);
      #1;
      if (tc) begin
        tcs++;
        if (first_tc < 0) first_tc = c;
        else tc_gap = c - first_tc;
      end
      tick();
      up2 = up2 + 2'd1;
      if (int'(q) != last_q) adv++;
      last_q = q;
    end
    check("gap_advances", adv, 20);
    check("gap_tc_pulses", tcs, 2);
    check("gap_tc_period", tc_gap, 40);
    check("gap_q_end", q, 0);

    // Mid-count asynchronous reset at Q=7, released between edges.
    ce_in = 1'b0; load = 1'b1; load_val = 4'd7;
    tick();
    load = 1'b0;
    check("pre_rst_q", q, 7);
    check("pre_rst_wr", wrapped, 1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_q", q, 0);
    check("mid_rst_tcq", tc_q, 0);
    check("mid_rst_wr", wrapped, 0);
    ce_in = 1'b1; up = 1'b1;
    #1 rst_n = 1'b1;
    tick();
    check("post_rst_q", q, 1);

    // Randomized run on both moduli against the arithmetic model.
    ce_in = 1'b0;
    pulse_reset();
    m10 = '{q: 0, tcq: 0, wr: 0};
    m16 = '{q: 0, tcq: 0, wr: 0};
    for (int i = 0; i < 400; i++) begin
      ce_in    = ($urandom_range(0, 9) < 7);
      up       = $urandom_range(0, 1) == 1;
      load     = ($urandom_range(0, 9) == 0);
      load_val = 4'($urandom);
      clr_flag = ($urandom_range(0, 7) == 0);
      #1;
      check("rnd_tc10", tc, model_tc(m10, 10, load, ce_in, up));
      check("rnd_tc16", tc16, model_tc(m16, 16, load, ce_in, up));
      m10 = model_step(m10, 10, load, int'(load_val), ce_in, up, clr_flag);
      m16 = model_step(m16, 16, load, int'(load_val), ce_in, up, clr_flag);
      tick();
      check("rnd_q10", q, m10.q);
      check("rnd_tcq10", tc_q, m10.tcq);
      check("rnd_wr10", wrapped, m10.wr);
      check("rnd_q16", q16, m16.q);
      check("rnd_tcq16", tc_q16, m16.tcq);
      check("rnd_wr16", wrapped16, m16.wr);
    end

    // Two-digit chain: units carry feeds tens enable.
    ce_in = 1'b0; load = 1'b0; clr_flag = 1'b0;
    pulse_reset();
    ch_ce = 1'b1;
    saw_nine = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      check("chain_value", int'(t_q) * 10 + int'(u_q), i);
      check("chain_tens_tc", t_tc, i == 99);
      if (t_q == 4'd9) saw_nine = 1'b1;
      tick();
    end
    ch_ce = 1'b0;
    check("chain_end_value", int'(t_q) * 10 + int'(u_q), 0);
    check("chain_tens_saw9", saw_nine, 1);
    check("chain_tens_tcq", t_tcq, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
